// File: rtl/dig_lock_pkg.sv
// Shared types and sizing helpers for the dig_lock_seq keypad lock controller.
// Optional lockout is enabled by defining DIG_LOCK_LOCKOUT_EN.
package dig_lock_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [15:0] DEF_CODE = 16'h1234;

  // Wide enough for the longer of the two dwell periods, never narrower than 1 bit.
  function automatic int timer_w(input int open_cyc, input int lock_cyc);
    int m;
    m = (open_cyc > lock_cyc) ? open_cyc : lock_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int fail_w(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

endpackage

// File: rtl/dig_lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
// Counts down to zero and holds there until reloaded.
module dig_lock_timer
  import dig_lock_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dig_lock_seq.sv
// Keypad lock controller: symbol window, Mealy unlock on enter, timed door-open,
// in-field code reprogramming; failed-attempt lockout when DIG_LOCK_LOCKOUT_EN is defined.
module dig_lock_seq
  import dig_lock_pkg::*;
#(
  parameter int SYM_W    = 4,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*SYM_W-1:0] RST_CODE = DEF_CODE,
  parameter int OPEN_CYC = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sym_valid,
  input  logic [SYM_W-1:0]                sym,
  input  logic                            enter,
  input  logic                            prog_valid,
  input  logic [CODE_LEN*SYM_W-1:0]       prog_code,
  output logic                            unlock,
  output logic                            door_open,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW    = CODE_LEN * SYM_W;
  localparam int TW    = timer_w(OPEN_CYC, LOCK_CYC);
  localparam int FW    = fail_w(MAX_FAIL);
  localparam int FILLW = $clog2(CODE_LEN + 1);

  state_t            state, state_n;
  logic [CW-1:0]     window, window_n, code, cmp_vec;
  logic [FILLW-1:0]  fill, fill_n;
  logic [FW-1:0]     fail_n;
  logic              full, match, unlock_raw;
  logic              timer_load, timer_zero;
  logic [TW-1:0]     timer_val;

  // The symbol arriving with enter takes part in the compare.
  assign cmp_vec = sym_valid ? {window[CW-SYM_W-1:0], sym} : window;
  assign full    = (fill == FILLW'(CODE_LEN)) ||
                   (sym_valid && (fill == FILLW'(CODE_LEN - 1)));
  assign match   = full && (cmp_vec == code);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    window_n   = window;
    fill_n     = fill;
    fail_n     = fail_cnt;
    unlock_raw = 1'b0;
    case (state)
      ARMED: begin
        if (enter) begin
          window_n = '0;
          fill_n   = '0;
          if (match) begin
            unlock_raw = 1'b1;
            state_n    = OPEN;
            fail_n     = '0;
          end else begin
`ifdef DIG_LOCK_LOCKOUT_EN
            fail_n = fail_cnt + FW'(1);
            if (fail_n == FW'(MAX_FAIL)) state_n = LOCKOUT;
`else
            if (fail_cnt != FW'(MAX_FAIL)) fail_n = fail_cnt + FW'(1);
`endif
          end
        end else if (sym_valid) begin
          window_n = cmp_vec;
          if (fill != FILLW'(CODE_LEN)) fill_n = fill + FILLW'(1);
        end
      end
      OPEN: begin
        if (timer_zero) state_n = ARMED;
      end
`ifdef DIG_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_zero) begin
          state_n = ARMED;
          fail_n  = '0;
        end
      end
`endif
      default: state_n = ARMED;
    endcase
  end

  // Reload on every state change; the value only matters for the timed states.
  assign timer_load = (state_n != state);
`ifdef DIG_LOCK_LOCKOUT_EN
  assign timer_val  = (state_n == LOCKOUT) ? TW'(LOCK_CYC - 1) : TW'(OPEN_CYC - 1);
`else
  assign timer_val  = TW'(OPEN_CYC - 1);
`endif

  dig_lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign unlock = unlock_raw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARMED;
      window    <= '0;
      fill      <= '0;
      fail_cnt  <= '0;
      code      <= RST_CODE;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      window    <= window_n;
      fill      <= fill_n;
      fail_cnt  <= fail_n;
      door_open <= (state_n == OPEN);
      if (state == OPEN && prog_valid) code <= prog_code;
    end
  end

`ifdef DIG_LOCK_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) locked_out <= 1'b0;
    else        locked_out <= (state_n == LOCKOUT);
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_dig_lock_seq.sv
// Self-checking bench for dig_lock_seq: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_dig_lock_seq;

  localparam int W     = 4;
  localparam int L     = 4;
  localparam int CW    = W * L;
  localparam int OPENC = 8;
  localparam int MAXF  = 3;
  localparam int LOCKC = 16;
  localparam logic [CW-1:0] RSTC = 16'h1234;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sym_valid = 1'b0;
  logic [W-1:0]  sym = '0;
  logic          enter = 1'b0;
  logic          prog_valid = 1'b0;
  logic [CW-1:0] prog_code = '0;
  logic          unlock, door_open, locked_out;
  logic [1:0]    fail_cnt;

  dig_lock_seq #(
    .SYM_W(W), .CODE_LEN(L), .RST_CODE(RSTC),
    .OPEN_CYC(OPENC), .MAX_FAIL(MAXF), .LOCK_CYC(LOCKC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .enter      (enter),
    .prog_valid (prog_valid),
    .prog_code  (prog_code),
    .unlock     (unlock),
    .door_open  (door_open),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: recent-symbol queue plus remaining-cycle counters.
  int            m_hist[$];
  logic [CW-1:0] m_code = RSTC;
  int            m_fail = 0;
  int            m_open = 0;
  int            m_lock = 0;

  function automatic logic m_match();
    int q[$];
    logic [CW-1:0] v;
    q = m_hist;
    if (sym_valid) q.push_back(int'(sym));
    if (q.size() < L) return 1'b0;
    v = '0;
    for (int i = q.size() - L; i < q.size(); i++) v = (v << W) | CW'(q[i]);
    return v == m_code;
  endfunction

  function automatic logic m_unlock();
    return reset && m_open == 0 && m_lock == 0 && enter && m_match();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hist.delete();
      m_code = RSTC;
      m_fail = 0;
      m_open = 0;
      m_lock = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (m_open > 0) begin
      if (prog_valid) m_code = prog_code;
      m_open--;
    end else if (enter) begin
      if (m_match()) begin
        m_open = OPENC;
        m_fail = 0;
      end else begin
`ifdef DIG_LOCK_LOCKOUT_EN
        m_fail++;
        if (m_fail == MAXF) m_lock = LOCKC;
`else
        if (m_fail < MAXF) m_fail++;
`endif
      end
      m_hist.delete();
    end else if (sym_valid) begin
      m_hist.push_back(int'(sym));
      if (m_hist.size() > L) void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("unlock",     32'(unlock),     32'(m_unlock()));
      check("door_open",  32'(door_open),  32'(m_open > 0));
      check("locked_out", 32'(locked_out), 32'(m_lock > 0));
      check("fail_cnt",   32'(fail_cnt),   32'(m_fail));
    end
  end

  task automatic step(input logic sv, input logic [W-1:0] s, input logic en,
                      input logic pv = 1'b0, input logic [CW-1:0] pc = '0,
                      input logic rs = 1'b1);
    @(posedge clk);
    #1;
    reset = rs; sym_valid = sv; sym = s; enter = en; prog_valid = pv; prog_code = pc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  // Types a full code, most significant symbol first, with enter on the last symbol.
  task automatic type_code(input logic [CW-1:0] c);
    for (int i = L - 1; i > 0; i--) step(1'b1, c[i*W +: W], 1'b0);
    step(1'b1, c[W-1:0], 1'b1);
  endtask

  initial begin
    #1 reset = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_door_open", 32'(door_open), 32'd0);
    check("rst_fail_cnt",  32'(fail_cnt),  32'd0);
    check("rst_unlock",    32'(unlock),    32'd0);
    step(1'b0, '0, 1'b0);

    // Defaults: unlock same cycle, door open exactly OPENC cycles.
    type_code(16'h1234);
    #2 check("dflt_unlock", 32'(unlock), 32'd1);
    for (int i = 0; i < OPENC; i++) begin
      idle(1);
      #2 check("dflt_door_high", 32'(door_open), 32'd1);
    end
    idle(1);
    #2 check("dflt_door_low", 32'(door_open), 32'd0);

    // Overlap: only the last four symbols count.
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b0, '0, 1'b1);
    #2 check("ovl_unlock", 32'(unlock), 32'd1);
    idle(1);
    #2 check("ovl_fail_cnt", 32'(fail_cnt), 32'd0);
    idle(OPENC);

    // Short entry fails; a full code then clears the count.
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b0, '0, 1'b1);
    #2 check("short_unlock", 32'(unlock), 32'd0);
    idle(1);
    #2 check("short_fail_cnt", 32'(fail_cnt), 32'd1);
    type_code(16'h1234);
    #2 check("short_retry_unlock", 32'(unlock), 32'd1);
    idle(1);
    #2 check("short_retry_fail", 32'(fail_cnt), 32'd0);
    idle(OPENC);

    // Reprogram while open.
    type_code(16'h1234);
    step(1'b0, '0, 1'b0, 1'b1, 16'hABCD);
    idle(OPENC);
    type_code(16'h1234);
    #2 check("prog_old_code", 32'(unlock), 32'd0);
    type_code(16'hABCD);
    #2 check("prog_new_code", 32'(unlock), 32'd1);

    // Reset in OPEN cycle 3 aborts and reverts the code.
    idle(2);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2 check("rst_mid_door", 32'(door_open), 32'd0);
    step(1'b0, '0, 1'b0);
    #2 check("rst_mid_fail", 32'(fail_cnt), 32'd0);
    type_code(16'hABCD);
    #2 check("rst_mid_abcd", 32'(unlock), 32'd0);
    type_code(16'h1234);
    #2 check("rst_mid_1234", 32'(unlock), 32'd1);
    idle(OPENC);

    // Repeated failures.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
`ifdef DIG_LOCK_LOCKOUT_EN
    for (int i = 0; i < LOCKC; i++) begin
      if (i < L - 1)       step(1'b1, RSTC[(L-1-i)*W +: W], 1'b0);
      else if (i == L - 1) step(1'b1, RSTC[W-1:0], 1'b1);
      else                 idle(1);
      #2 check("lock_high", 32'(locked_out), 32'd1);
      if (i == L - 1) check("lock_unlock", 32'(unlock), 32'd0);
    end
    idle(1);
    #2 check("lock_exit", 32'(locked_out), 32'd0);
    check("lock_exit_fail", 32'(fail_cnt), 32'd0);
`else
    idle(1);
    #2 check("sat_fail3", 32'(fail_cnt), 32'd3);
    step(1'b0, '0, 1'b1);
    idle(1);
    #2 check("sat_fail_hold", 32'(fail_cnt), 32'd3);
    check("sat_no_lock", 32'(locked_out), 32'd0);
`endif
    type_code(16'h1234);
    #2 check("after_fail_unlock", 32'(unlock), 32'd1);
    idle(OPENC);

    // Randomized traffic, checked by the compare process.
    for (int it = 0; it < 800; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        type_code(m_code);
      end else if (r == 2) begin
        step(1'b0, '0, 1'b1);
      end else if (r == 3) begin
        step(1'($urandom_range(0, 1)), W'($urandom_range(0, 5)), 1'b0, 1'b1,
             ($urandom_range(0, 1) == 0) ? RSTC : CW'($urandom));
      end else if (r == 4 && $urandom_range(0, 19) == 0) begin
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      end else begin
        step(1'($urandom_range(0, 1)), W'($urandom_range(0, 5)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), CW'($urandom));
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
